// File: rtl/hit_buffer_l1_ctrl_pkg.sv
// Shared widths and constants for the hit-buffer / L1-buffer controller.
package hit_buffer_l1_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH    = 9;
    localparam int unsigned L1_ADDR_WIDTH = 5;

    localparam int unsigned              OVF_CNT_WIDTH = 8;
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_CNT_MAX   = '1;

endpackage

// File: rtl/hit_buffer_l1_ctrl_if.sv
// Hit-buffer, L1-buffer and readout signals of the controller.
interface hit_buffer_l1_ctrl_if
    import hit_buffer_l1_ctrl_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = ADDR_WIDTH,
    parameter int unsigned L1ADDRWIDTH = L1_ADDR_WIDTH
) ();

    logic [ADDRWIDTH-1:0]     latency;
    logic                     L1A;
    logic [ADDRWIDTH-1:0]     hbWrAddr;
    logic [ADDRWIDTH-1:0]     hbRdAddr;
    logic                     hbRden;
    logic                     hbOutHit;
    logic                     l1Wren;
    logic [L1ADDRWIDTH-1:0]   l1WrAddr;
    logic                     l1Hit;
    logic                     l1Rden;
    logic [L1ADDRWIDTH-1:0]   l1RdAddr;
    logic                     l1OutHit;
    logic                     rdReq;
    logic                     rdValid;
    logic                     rdHit;
    logic                     empty;
    logic                     full;
    logic [L1ADDRWIDTH:0]     occupancy;
    logic [OVF_CNT_WIDTH-1:0] overflowCnt;

    // Controller side
    modport master (
        input  latency, L1A, hbOutHit, l1OutHit, rdReq,
        output hbWrAddr, hbRdAddr, hbRden, l1Wren, l1WrAddr, l1Hit,
               l1Rden, l1RdAddr, rdValid, rdHit, empty, full, occupancy,
               overflowCnt
    );

    // Parent / SRAM wrapper / readout side
    modport slave (
        output latency, L1A, hbOutHit, l1OutHit, rdReq,
        input  hbWrAddr, hbRdAddr, hbRden, l1Wren, l1WrAddr, l1Hit,
               l1Rden, l1RdAddr, rdValid, rdHit, empty, full, occupancy,
               overflowCnt
    );

endinterface

// File: rtl/hit_buffer_l1_ctrl_l1_fifo_ptr_ctrl.sv
// L1 event buffer FIFO bookkeeping: pointers, occupancy, flags, accept logic.
module l1_fifo_ptr_ctrl
    import hit_buffer_l1_ctrl_pkg::*;
#(
    parameter int unsigned AW = L1_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          push_ok,
    output logic          push_drop,
    output logic          pop_ok,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   occupancy,
    output logic          full,
    output logic          empty
);

    localparam int unsigned OW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;

    // Flags come from registered occupancy; a full buffer refuses pushes even with a pop
    assign full      = (occ_q == OW'(DEPTH));
    assign empty     = (occ_q == '0);
    assign push_ok   = reset & push_req & ~full;
    assign push_drop = reset & push_req & full;
    assign pop_ok    = reset & pop_req & ~empty;

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign occupancy = occ_q;

    // Pointer advance and occupancy tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      occ_q <= occ_q + OW'(1);
            else if (!push_ok && pop_ok) occ_q <= occ_q - OW'(1);
        end
    end

endmodule

// File: rtl/hit_buffer_l1_ctrl.sv
// Hit-buffer addressing, trigger retrieval and L1 event buffer control.
module hit_buffer_l1_ctrl
    import hit_buffer_l1_ctrl_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = ADDR_WIDTH,
    parameter int unsigned L1ADDRWIDTH = L1_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    hit_buffer_l1_ctrl_if.master bus
);

    logic [ADDRWIDTH-1:0]     wr_addr_q;
    logic                     p1_q;
    logic                     rd_valid_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_q;

    logic                     push_ok;
    logic                     push_drop;
    logic                     pop_ok;
    logic [L1ADDRWIDTH-1:0]   wr_ptr;
    logic [L1ADDRWIDTH-1:0]   rd_ptr;
    logic [L1ADDRWIDTH:0]     occupancy;
    logic                     full;
    logic                     empty;

    // Free-running circular write pointer of the hit buffer
    always_ff @(posedge clk) begin
        if (!reset) wr_addr_q <= '0;
        else        wr_addr_q <= wr_addr_q + ADDRWIDTH'(1);
    end

    // Trigger pending flag: hit-buffer data lands one cycle after the read
    always_ff @(posedge clk) begin
        if (!reset) p1_q <= 1'b0;
        else        p1_q <= bus.L1A;
    end

    // Saturating count of triggers dropped on a full L1 buffer
    always_ff @(posedge clk) begin
        if (!reset)                                 ovf_q <= '0;
        else if (push_drop && ovf_q != OVF_CNT_MAX) ovf_q <= ovf_q + OVF_CNT_WIDTH'(1);
    end

    // Readout strobe follows an accepted pop by one cycle
    always_ff @(posedge clk) begin
        if (!reset) rd_valid_q <= 1'b0;
        else        rd_valid_q <= pop_ok;
    end

    l1_fifo_ptr_ctrl #(
        .AW (L1ADDRWIDTH)
    ) u_l1_fifo_ptr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .push_req  (p1_q),
        .pop_req   (bus.rdReq),
        .push_ok   (push_ok),
        .push_drop (push_drop),
        .pop_ok    (pop_ok),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign bus.hbWrAddr    = wr_addr_q;
    assign bus.hbRdAddr    = wr_addr_q - bus.latency;
    assign bus.hbRden      = bus.L1A & reset;
    assign bus.l1Wren      = push_ok;
    assign bus.l1WrAddr    = wr_ptr;
    assign bus.l1Hit       = bus.hbOutHit;
    assign bus.l1Rden      = pop_ok;
    assign bus.l1RdAddr    = rd_ptr;
    assign bus.rdValid     = rd_valid_q;
    assign bus.rdHit       = bus.l1OutHit;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.occupancy   = occupancy;
    assign bus.overflowCnt = ovf_q;

endmodule

// File: tb/tb_hit_buffer_l1_ctrl.sv
// Self-checking bench for hit_buffer_l1_ctrl with SRAM models and a queue-based reference.
module tb_hit_buffer_l1_ctrl;

    logic clk;
    logic reset;
    logic hit_in;

    hit_buffer_l1_ctrl_if bus ();

    hit_buffer_l1_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM wrappers: synchronous read, data valid the next cycle
    bit   hb_mem [512];
    bit   l1_mem [32];
    logic hb_out = 1'b0;
    logic l1_out = 1'b0;

    always @(posedge clk) begin
        if (bus.hbRden) hb_out <= hb_mem[bus.hbRdAddr];
        hb_mem[bus.hbWrAddr] <= hit_in;
        if (bus.l1Wren) l1_mem[bus.l1WrAddr] <= bus.l1Hit;
        if (bus.l1Rden) l1_out <= l1_mem[bus.l1RdAddr];
    end

    assign bus.hbOutHit = hb_out;
    assign bus.l1OutHit = l1_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int cyc;
    int lat;
    bit q[$];
    bit pend;
    bit pend_hit;
    int ovf;
    bit pop_prev;
    bit pop_val;
    bit wr_log [512];
    int force_hit = -1;

    // Observed and expected values for the current cycle
    logic [8:0] obs_wr, obs_hbrd;
    logic       obs_hbrden, obs_wren, obs_hit, obs_rden, obs_rdvalid, obs_rdhit;
    logic       obs_full, obs_empty;
    logic [5:0] obs_occ;
    logic [7:0] obs_ovf;
    int         exp_wr, exp_hbrd, exp_occ, exp_ovf;
    bit         exp_hbrden, exp_wren, exp_hit, exp_rden, exp_rdvalid, exp_rdhit;
    bit         exp_full, exp_empty;

    task automatic model_reset();
        cyc = 0; q.delete(); pend = 0; pend_hit = 0; ovf = 0; pop_prev = 0; pop_val = 0;
    endtask

    // One clock cycle out of reset: drive, sample mid-cycle, advance the reference
    task automatic tick(input bit l1a, input bit rq);
        int cnt;
        bus.L1A   = l1a;
        bus.rdReq = rq;
        hit_in    = (force_hit < 0) ? 1'($urandom_range(0, 1)) : 1'(force_hit);
        @(negedge clk);
        obs_wr = bus.hbWrAddr; obs_hbrd = bus.hbRdAddr; obs_hbrden = bus.hbRden;
        obs_wren = bus.l1Wren; obs_hit = bus.l1Hit; obs_rden = bus.l1Rden;
        obs_rdvalid = bus.rdValid; obs_rdhit = bus.rdHit; obs_occ = bus.occupancy;
        obs_full = bus.full; obs_empty = bus.empty; obs_ovf = bus.overflowCnt;

        cnt         = q.size();
        exp_wr      = cyc % 512;
        exp_hbrd    = ((cyc - lat) % 512 + 512) % 512;
        exp_hbrden  = l1a;
        exp_wren    = pend && cnt < 32;
        exp_hit     = pend_hit;
        exp_rden    = rq && cnt > 0;
        exp_rdvalid = pop_prev;
        exp_rdhit   = pop_val;
        exp_occ     = cnt;
        exp_full    = (cnt == 32);
        exp_empty   = (cnt == 0);
        exp_ovf     = ovf;

        if (exp_rden) begin pop_val = q.pop_front(); pop_prev = 1; end
        else pop_prev = 0;
        if (exp_wren) q.push_back(pend_hit);
        else if (pend && ovf < 255) ovf++;
        pend = l1a;
        if (l1a) pend_hit = wr_log[exp_hbrd];
        wr_log[exp_wr] = hit_in;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; bus.L1A = 1'b0; bus.rdReq = 1'b0; hit_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.L1A = 1'b1; bus.rdReq = 1'b1; hit_in = 1'b0;
        bus.latency = 9'd4; lat = 4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.hbRden !== 1'b0) begin n_fail++; $display("FAIL reset_hbRden got %0b want 0", bus.hbRden); end
        n_checks++; if (bus.l1Rden !== 1'b0) begin n_fail++; $display("FAIL reset_l1Rden got %0b want 0", bus.l1Rden); end
        n_checks++; if (bus.l1Wren !== 1'b0) begin n_fail++; $display("FAIL reset_l1Wren got %0b want 0", bus.l1Wren); end
        @(posedge clk);
        #1;
        reset = 1'b1; bus.L1A = 1'b0; bus.rdReq = 1'b0;
        model_reset();
        tick(0, 0);
        n_checks++; if (obs_wr !== 9'd0) begin n_fail++; $display("FAIL reset_hbWrAddr got %0d want 0", obs_wr); end
        n_checks++; if (obs_occ !== 6'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", obs_occ); end
        n_checks++; if (obs_empty !== 1'b1 || obs_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", obs_empty, obs_full); end
        n_checks++; if (obs_ovf !== 8'd0 || obs_rdvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_rdValid got %0d/%0b want 0/0", obs_ovf, obs_rdvalid); end
    endtask

    task automatic test_latency_readback();
        do_reset();
        bus.latency = 9'd10; lat = 10;
        while (cyc < 110) begin
            force_hit = (cyc == 100) ? 1 : -1;
            tick(0, 0);
        end
        force_hit = -1;
        tick(1, 0);
        n_checks++; if (obs_wr !== 9'd110) begin n_fail++; $display("FAIL lat_hbWrAddr got %0d want 110", obs_wr); end
        n_checks++; if (obs_hbrd !== 9'd100) begin n_fail++; $display("FAIL lat_hbRdAddr got %0d want 100", obs_hbrd); end
        n_checks++; if (obs_hbrden !== 1'b1) begin n_fail++; $display("FAIL lat_hbRden got %0b want 1", obs_hbrden); end
        tick(0, 0);
        n_checks++; if (obs_wren !== 1'b1 || obs_hit !== 1'b1) begin n_fail++; $display("FAIL lat_push got wren=%0b hit=%0b want 1/1", obs_wren, obs_hit); end
        tick(0, 0);
        n_checks++; if (obs_occ !== 6'd1) begin n_fail++; $display("FAIL lat_occupancy got %0d want 1", obs_occ); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.latency = 9'd5; lat = 5;
        while (cyc < 514) tick(0, 0);
        tick(1, 0);
        n_checks++; if (obs_hbrd !== 9'd509) begin n_fail++; $display("FAIL wrap_hbRdAddr got %0d want 509", obs_hbrd); end
        tick(0, 0);
        n_checks++; if (obs_wren !== 1'b1 || obs_hit !== exp_hit) begin n_fail++; $display("FAIL wrap_push got wren=%0b hit=%0b want 1/%0b", obs_wren, obs_hit, exp_hit); end
    endtask

    task automatic test_fill_overflow();
        int pulses = 0;
        do_reset();
        bus.latency = 9'd3; lat = 3;
        repeat (4) tick(0, 0);
        repeat (34) tick(1, 0);
        repeat (2) tick(0, 0);
        n_checks++; if (obs_occ !== 6'd32 || obs_full !== 1'b1) begin n_fail++; $display("FAIL fill_occupancy got %0d full=%0b want 32/1", obs_occ, obs_full); end
        n_checks++; if (obs_ovf !== 8'd2) begin n_fail++; $display("FAIL fill_overflowCnt got %0d want 2", obs_ovf); end
        for (int i = 0; i < 34; i++) begin
            tick(0, i < 33);
            if (obs_rdvalid === 1'b1) pulses++;
            n_checks++; if (obs_rdvalid !== exp_rdvalid) begin n_fail++; $display("FAIL drain_rdValid[%0d] got %0b want %0b", i, obs_rdvalid, exp_rdvalid); end
            if (exp_rdvalid) begin
                n_checks++; if (obs_rdhit !== exp_rdhit) begin n_fail++; $display("FAIL drain_rdHit[%0d] got %0b want %0b", i, obs_rdhit, exp_rdhit); end
            end
        end
        n_checks++; if (pulses != 32) begin n_fail++; $display("FAIL drain_pulses got %0d want 32", pulses); end
        n_checks++; if (obs_empty !== 1'b1 || obs_occ !== 6'd0) begin n_fail++; $display("FAIL drain_empty got %0b occ=%0d want 1/0", obs_empty, obs_occ); end
    endtask

    task automatic test_concurrent();
        do_reset();
        bus.latency = 9'd3; lat = 3;
        repeat (4) tick(0, 0);
        repeat (5) tick(1, 0);
        repeat (2) tick(0, 0);
        n_checks++; if (obs_occ !== 6'd5) begin n_fail++; $display("FAIL conc_prefill got %0d want 5", obs_occ); end
        tick(1, 0);
        tick(0, 1);
        n_checks++; if (obs_wren !== 1'b1 || obs_rden !== 1'b1) begin n_fail++; $display("FAIL conc_both got wren=%0b rden=%0b want 1/1", obs_wren, obs_rden); end
        tick(0, 0);
        n_checks++; if (obs_occ !== 6'd5) begin n_fail++; $display("FAIL conc_occupancy got %0d want 5", obs_occ); end

        do_reset();
        repeat (4) tick(0, 0);
        tick(1, 0);
        tick(0, 1);
        n_checks++; if (obs_wren !== 1'b1 || obs_rden !== 1'b0) begin n_fail++; $display("FAIL conc_empty got wren=%0b rden=%0b want 1/0", obs_wren, obs_rden); end
        tick(0, 0);
        n_checks++; if (obs_rdvalid !== 1'b0 || obs_occ !== 6'd1) begin n_fail++; $display("FAIL conc_empty_after got rdValid=%0b occ=%0d want 0/1", obs_rdvalid, obs_occ); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.latency = 9'd3; lat = 3;
        repeat (4) tick(0, 0);
        repeat (332) tick(1, 0);
        repeat (2) tick(0, 0);
        n_checks++; if (obs_ovf !== 8'd255 || obs_occ !== 6'd32) begin n_fail++; $display("FAIL sat_overflowCnt got %0d occ=%0d want 255/32", obs_ovf, obs_occ); end
        tick(1, 0);
        tick(0, 1);
        n_checks++; if (obs_wren !== 1'b0 || obs_rden !== 1'b1) begin n_fail++; $display("FAIL sat_popfull got wren=%0b rden=%0b want 0/1", obs_wren, obs_rden); end
        tick(0, 0);
        n_checks++; if (obs_occ !== 6'd31 || obs_ovf !== 8'd255) begin n_fail++; $display("FAIL sat_after got occ=%0d ovf=%0d want 31/255", obs_occ, obs_ovf); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.latency = 9'd3; lat = 3;
        repeat (4) tick(0, 0);
        repeat (3) tick(1, 0);
        tick(0, 0);
        tick(1, 0);
        reset = 1'b0; bus.L1A = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.l1Wren !== 1'b0) begin n_fail++; $display("FAIL midrst_l1Wren got %0b want 0", bus.l1Wren); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        tick(0, 0);
        n_checks++; if (obs_wr !== 9'd0 || obs_occ !== 6'd0 || obs_ovf !== 8'd0 || obs_rdvalid !== 1'b0 || obs_wren !== 1'b0)
            begin n_fail++; $display("FAIL midrst_release got wr=%0d occ=%0d ovf=%0d rdValid=%0b wren=%0b want all 0", obs_wr, obs_occ, obs_ovf, obs_rdvalid, obs_wren); end
    endtask

    task automatic test_random();
        int bad = 0;
        int pl, pr;
        do_reset();
        lat = $urandom_range(1, 40);
        bus.latency = 9'(lat);
        for (int i = 0; i < 1500; i++) begin
            pl = (i / 250) % 2 == 0 ? 70 : 30;
            pr = 100 - pl;
            tick(cyc >= lat && $urandom_range(0, 99) < pl, $urandom_range(0, 99) < pr);
            n_checks++;
            if (obs_wr !== 9'(exp_wr) || obs_hbrd !== 9'(exp_hbrd) || obs_hbrden !== exp_hbrden ||
                obs_wren !== exp_wren || obs_rden !== exp_rden || obs_rdvalid !== exp_rdvalid ||
                obs_occ !== 6'(exp_occ) || obs_full !== exp_full || obs_empty !== exp_empty ||
                obs_ovf !== 8'(exp_ovf) || (exp_wren && obs_hit !== exp_hit) || (exp_rdvalid && obs_rdhit !== exp_rdhit)) begin
                n_fail++;
                if (bad < 10) $display("FAIL random[%0d] got wr=%0d rd=%0d wren=%0b hit=%0b rden=%0b rv=%0b rh=%0b occ=%0d ovf=%0d want wr=%0d rd=%0d wren=%0b hit=%0b rden=%0b rv=%0b rh=%0b occ=%0d ovf=%0d",
                    i, obs_wr, obs_hbrd, obs_wren, obs_hit, obs_rden, obs_rdvalid, obs_rdhit, obs_occ, obs_ovf,
                    exp_wr, exp_hbrd, exp_wren, exp_hit, exp_rden, exp_rdvalid, exp_rdhit, exp_occ, exp_ovf);
                bad++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; hit_in = 1'b0; bus.L1A = 1'b0; bus.rdReq = 1'b0; bus.latency = 9'd1;
        lat = 1;
        model_reset();
        test_reset();
        test_latency_readback();
        test_wrap();
        test_fill_overflow();
        test_concurrent();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
